// File: rtl/uart_fifo_arbiter.sv
// Arbitrates two byte requesters onto the UART FIFO write port and streams FIFO
// reads into a small valid/ready output buffer that absorbs the registered read latency.
module uart_fifo_arbiter #(
  parameter int DEPTH      = 256,
  parameter int RD_LAT     = 2,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         req0_valid,
  input  logic [7:0]                   req0_data,
  output logic                         req0_ready,
  input  logic                         req1_valid,
  input  logic [7:0]                   req1_data,
  output logic                         req1_ready,
  output logic                         rd_valid,
  output logic [7:0]                   rd_data,
  input  logic                         rd_ready,
  output logic                         fifo_wrb,
  output logic [7:0]                   fifo_di,
  output logic                         fifo_rdb,
  input  logic [7:0]                   fifo_do,
  output logic                         fifo_resetn,
  input  logic [7:0]                   level,
  output logic [$clog2(DEPTH+1)-1:0]   occ,
  output logic                         level_hit
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int CNT_W = $clog2(OBUF_DEPTH + 1);
  localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_W:0]   OBUF_LIM = (CNT_W + 1)'(OBUF_DEPTH);
  localparam logic [CNT_W-1:0] OBUF_MAX = CNT_W'(OBUF_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OBUF_DEPTH - 1);

  logic             rst_dly_reg;
  logic             last_grant_reg, last_grant_next;
  logic [OCC_W-1:0] occ_reg, occ_next;
  logic [OCC_W-1:0] avail_reg, avail_next;
  logic [CNT_W-1:0] inflight_reg, inflight_next;
  logic [CNT_W-1:0] buf_count_reg, buf_count_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [7:0]       buf_mem [OBUF_DEPTH];
  logic             fifo_wrb_reg, fifo_rdb_reg;
  logic [7:0]       fifo_di_reg;
  logic [RD_LAT:1]  tag_reg, tag_next;

  logic             eligible, grant0, grant1, accept, issue, push, pop;
  logic [7:0]       accept_data;
  logic [CNT_W:0]   committed;

  always_comb begin
    eligible    = !RESET && (occ_reg < OCC_FULL);
    grant0      = eligible && req0_valid && (!req1_valid || last_grant_reg);
    grant1      = eligible && req1_valid && (!req0_valid || !last_grant_reg);
    accept      = grant0 || grant1;
    accept_data = grant1 ? req1_data : req0_data;
    pop         = (buf_count_reg != '0) && rd_ready;
    push        = tag_reg[RD_LAT];
    // A pop this cycle frees a slot before any new read can land, so it is
    // credited here; without that credit the stream stalls one cycle in five.
    committed   = {1'b0, inflight_reg} + {1'b0, buf_count_reg} - (CNT_W + 1)'(pop);
    issue       = !RESET && (avail_reg != '0) && (committed < OBUF_LIM);
  end

  // Read-tag pipeline: bit k is high k cycles after the read strobe.
  assign tag_next[1] = !fifo_rdb_reg;
  for (genvar gi = 2; gi <= RD_LAT; gi++) begin : g_tag
    assign tag_next[gi] = tag_reg[gi-1];
  end

  always_comb begin
    occ_next = occ_reg;
    case ({accept, issue})
      2'b10:   occ_next = occ_reg + OCC_W'(1);
      2'b01:   occ_next = occ_reg - OCC_W'(1);
      default: occ_next = occ_reg;
    endcase
    avail_next      = avail_reg + OCC_W'(!fifo_wrb_reg) - OCC_W'(issue);
    inflight_next   = inflight_reg + CNT_W'(issue) - CNT_W'(push);
    buf_count_next  = buf_count_reg + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    if (push) wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
    if (pop)  rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
    last_grant_next = last_grant_reg;
    if (grant1)      last_grant_next = 1'b1;
    else if (grant0) last_grant_next = 1'b0;
  end

  always_ff @(posedge CLK) begin
    rst_dly_reg <= RESET;
    if (RESET) begin
      last_grant_reg <= 1'b1;
      occ_reg        <= '0;
      avail_reg      <= '0;
      inflight_reg   <= '0;
      buf_count_reg  <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_wrb_reg   <= 1'b1;
      fifo_rdb_reg   <= 1'b1;
      fifo_di_reg    <= 8'h00;
      tag_reg        <= '0;
    end else begin
      last_grant_reg <= last_grant_next;
      occ_reg        <= occ_next;
      avail_reg      <= avail_next;
      inflight_reg   <= inflight_next;
      buf_count_reg  <= buf_count_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      fifo_wrb_reg   <= !accept;
      fifo_rdb_reg   <= !issue;
      tag_reg        <= tag_next;
      if (accept) fifo_di_reg <= accept_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) buf_mem[wr_ptr_reg] <= fifo_do;
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign rd_valid    = (buf_count_reg != '0);
  assign rd_data     = rd_valid ? buf_mem[rd_ptr_reg] : 8'h00;
  assign fifo_wrb    = fifo_wrb_reg;
  assign fifo_di     = fifo_di_reg;
  assign fifo_rdb    = fifo_rdb_reg;
  assign fifo_resetn = !(RESET || rst_dly_reg);
  assign occ         = occ_reg;
  assign level_hit   = (occ_reg >= OCC_W'(level));

  a_obuf_overflow: assert property (@(posedge CLK) disable iff (RESET)
    !(push && !pop && buf_count_reg == OBUF_MAX));
  a_inflight_underflow: assert property (@(posedge CLK) disable iff (RESET)
    !(push && inflight_reg == '0));
  a_avail_bound: assert property (@(posedge CLK) disable iff (RESET)
    (avail_reg <= occ_reg) && (occ_reg <= OCC_FULL));

endmodule
